// File: rtl/knownch_selector.sv
// Known cluster-head selector: collects advertised CH tuples during a heartbeat
// window, deduplicates by ID, then scans the table to pick the best CH.
module knownch_selector #(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned MAX_CH     = 16,
    parameter int unsigned IDX_W      = $clog2(MAX_CH) + 1
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en_KCH,
    input  logic                  HB_reset,
    input  logic [WORD_WIDTH-1:0] HB_CHlimit,
    input  logic                  fch_valid,
    input  logic [WORD_WIDTH-1:0] fCH_ID,
    input  logic [WORD_WIDTH-1:0] fCH_Hops,
    input  logic [WORD_WIDTH-1:0] fCH_QValue,
    input  logic                  collect_done,
    output logic                  busy,
    output logic                  choose_valid,
    output logic                  no_ch,
    output logic                  overflow,
    output logic [IDX_W-1:0]      ch_count,
    output logic [WORD_WIDTH-1:0] chosenCH,
    output logic [WORD_WIDTH-1:0] hopsfromCH,
    output logic [WORD_WIDTH-1:0] chosenQ
);

    localparam int unsigned AW = $clog2(MAX_CH);
    localparam logic [WORD_WIDTH-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_SCAN,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [MAX_CH-1:0]     ent_valid;
    logic [WORD_WIDTH-1:0] ent_id   [MAX_CH];
    logic [WORD_WIDTH-1:0] ent_hops [MAX_CH];
    logic [WORD_WIDTH-1:0] ent_q    [MAX_CH];

    logic [IDX_W-1:0]      limit;
    logic [IDX_W-1:0]      limit_eff;
    logic [IDX_W-1:0]      scan_idx;
    logic [WORD_WIDTH-1:0] best_id, best_hops, best_q;

    logic [MAX_CH-1:0]     hit_vec;
    logic                  hit;
    logic [AW-1:0]         hit_idx;
    logic [AW-1:0]         wr_idx;
    logic                  has_room;

    logic                  do_insert, ins_new, ins_drop, ins_write;
    logic                  latch_limit, scan_step, do_done, scan_last;

    logic [WORD_WIDTH-1:0] cand_id, cand_hops, cand_q;
    logic                  cand_better;

    // Parallel ID match against all valid entries
    always_comb begin
        hit_vec = '0;
        hit_idx = '0;
        for (int i = 0; i < int'(MAX_CH); i++) begin
            hit_vec[i] = ent_valid[i] && (ent_id[i] == fCH_ID);
        end
        for (int i = 0; i < int'(MAX_CH); i++) begin
            if (hit_vec[i]) hit_idx = AW'(i);
        end
        hit = |hit_vec;
    end

    always_comb begin
        if ((HB_CHlimit == '0) || (HB_CHlimit > WORD_WIDTH'(MAX_CH)))
            limit_eff = IDX_W'(MAX_CH);
        else
            limit_eff = IDX_W'(HB_CHlimit);
    end

    // Candidate under scan and the Q / hops / ID preference order
    always_comb begin
        cand_id     = ent_id[scan_idx[AW-1:0]];
        cand_hops   = ent_hops[scan_idx[AW-1:0]];
        cand_q      = ent_q[scan_idx[AW-1:0]];
        cand_better = (cand_q > best_q) ||
                      ((cand_q == best_q) &&
                       ((cand_hops < best_hops) ||
                        ((cand_hops == best_hops) && (cand_id < best_id))));
        scan_last   = (ch_count != '0) && (scan_idx == (ch_count - IDX_W'(1)));
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next state and datapath strobes
    always_comb begin
        state_next  = state;
        do_insert   = 1'b0;
        latch_limit = 1'b0;
        scan_step   = 1'b0;
        do_done     = 1'b0;
        if (HB_reset) begin
            state_next = S_IDLE;
        end else if (en_KCH) begin
            case (state)
                S_IDLE: begin
                    latch_limit = 1'b1;
                    state_next  = S_COLLECT;
                end
                S_COLLECT: begin
                    do_insert = fch_valid;
                    if (collect_done) state_next = S_SCAN;
                end
                S_SCAN: begin
                    scan_step = (ch_count != '0);
                    if ((ch_count == '0) || scan_last) state_next = S_DONE;
                end
                S_DONE: begin
                    do_done    = 1'b1;
                    state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        has_room  = (ch_count < limit);
        ins_new   = do_insert && !hit && has_room;
        ins_drop  = do_insert && !hit && !has_room;
        ins_write = (do_insert && hit) || ins_new;
        wr_idx    = hit ? hit_idx : ch_count[AW-1:0];
    end

    // Occupancy, count, sticky overflow and latched window limit
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ent_valid <= '0;
            ch_count  <= '0;
            overflow  <= 1'b0;
            limit     <= IDX_W'(MAX_CH);
        end else if (HB_reset) begin
            ent_valid <= '0;
            ch_count  <= '0;
            overflow  <= 1'b0;
            limit     <= IDX_W'(MAX_CH);
        end else begin
            if (latch_limit) limit <= limit_eff;
            if (ins_new) begin
                ent_valid[wr_idx] <= 1'b1;
                ch_count          <= ch_count + IDX_W'(1);
            end
            if (ins_drop) overflow <= 1'b1;
        end
    end

    // Table payload; qualified by ent_valid so no reset is needed
    always_ff @(posedge clk) begin
        if (ins_write) begin
            ent_id[wr_idx]   <= fCH_ID;
            ent_hops[wr_idx] <= fCH_Hops;
            ent_q[wr_idx]    <= fCH_QValue;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            scan_idx  <= '0;
            best_id   <= ALL_ONES;
            best_hops <= ALL_ONES;
            best_q    <= ALL_ONES;
        end else if (HB_reset) begin
            scan_idx  <= '0;
            best_id   <= ALL_ONES;
            best_hops <= ALL_ONES;
            best_q    <= ALL_ONES;
        end else if (scan_step) begin
            scan_idx <= scan_idx + IDX_W'(1);
            if ((scan_idx == '0) || cand_better) begin
                best_id   <= cand_id;
                best_hops <= cand_hops;
                best_q    <= cand_q;
            end
        end else if (state != S_SCAN) begin
            scan_idx <= '0;
        end
    end

    // Result registers update only in DONE and hold otherwise
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            busy         <= 1'b0;
            choose_valid <= 1'b0;
            no_ch        <= 1'b0;
            chosenCH     <= ALL_ONES;
            hopsfromCH   <= ALL_ONES;
            chosenQ      <= ALL_ONES;
        end else if (HB_reset) begin
            busy         <= 1'b0;
            choose_valid <= 1'b0;
            no_ch        <= 1'b0;
            chosenCH     <= ALL_ONES;
            hopsfromCH   <= ALL_ONES;
            chosenQ      <= ALL_ONES;
        end else begin
            busy         <= (state_next == S_COLLECT) || (state_next == S_SCAN);
            choose_valid <= do_done;
            if (do_done) begin
                no_ch <= (ch_count == '0);
                if (ch_count == '0) begin
                    chosenCH   <= ALL_ONES;
                    hopsfromCH <= ALL_ONES;
                    chosenQ    <= ALL_ONES;
                end else begin
                    chosenCH   <= best_id;
                    hopsfromCH <= best_hops;
                    chosenQ    <= best_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_knownch_selector.sv
// Self-checking bench for knownch_selector: table of collection windows plus
// hand-written disturbance sequences, results checked through a scoreboard.
module tb_knownch_selector;

    localparam int unsigned W  = 16;
    localparam int unsigned N  = 16;
    localparam int unsigned IW = $clog2(N) + 1;

    logic          clk = 1'b0;
    logic          nrst;
    logic          en_KCH;
    logic          HB_reset;
    logic [W-1:0]  HB_CHlimit;
    logic          fch_valid;
    logic [W-1:0]  fCH_ID, fCH_Hops, fCH_QValue;
    logic          collect_done;
    logic          busy, choose_valid, no_ch, overflow;
    logic [IW-1:0] ch_count;
    logic [W-1:0]  chosenCH, hopsfromCH, chosenQ;

    knownch_selector #(.WORD_WIDTH(W), .MAX_CH(N), .IDX_W(IW)) dut (
        .clk(clk), .nrst(nrst), .en_KCH(en_KCH), .HB_reset(HB_reset),
        .HB_CHlimit(HB_CHlimit), .fch_valid(fch_valid), .fCH_ID(fCH_ID),
        .fCH_Hops(fCH_Hops), .fCH_QValue(fCH_QValue), .collect_done(collect_done),
        .busy(busy), .choose_valid(choose_valid), .no_ch(no_ch), .overflow(overflow),
        .ch_count(ch_count), .chosenCH(chosenCH), .hopsfromCH(hopsfromCH),
        .chosenQ(chosenQ)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cnt;
        logic [15:0] ch;
        logic [15:0] h;
        logic [15:0] q;
        logic        noch;
        logic        ov;
        int          lat;
    } exp_t;

    typedef struct {
        int          limit;
        int          n;
        logic [15:0] id [4];
        logic [15:0] hp [4];
        logic [15:0] qv [4];
        exp_t        e;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Clear via HB_reset, latch the limit on entry to COLLECT, then disturb HB_CHlimit
    task automatic start_window(input int lim);
        HB_CHlimit = W'(lim);
        HB_reset   = 1'b1;
        step();
        HB_reset   = 1'b0;
        step();
        HB_CHlimit = '0;
    endtask

    task automatic send(input logic [15:0] id, input logic [15:0] hp, input logic [15:0] qv);
        fch_valid  = 1'b1;
        fCH_ID     = id;
        fCH_Hops   = hp;
        fCH_QValue = qv;
        step();
        fch_valid  = 1'b0;
    endtask

    // Close the window; the expectation waits in the scoreboard until choose_valid
    task automatic close_and_check(input string tag, input exp_t e);
        exp_t r;
        int   lat;
        bit   got;
        sb.push_back(e);
        collect_done = 1'b1;
        step();
        collect_done = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 200) begin
            step();
            lat++;
            if (choose_valid) got = 1'b1;
        end
        r = sb.pop_front();
        if (!got) begin
            chk({tag, ".choose_valid_timeout"}, 32'(choose_valid), 32'd1);
        end else begin
            chk({tag, ".latency"},  32'(lat),        32'(r.lat));
            chk({tag, ".chosenCH"}, 32'(chosenCH),   32'(r.ch));
            chk({tag, ".hops"},     32'(hopsfromCH), 32'(r.h));
            chk({tag, ".chosenQ"},  32'(chosenQ),    32'(r.q));
            chk({tag, ".no_ch"},    32'(no_ch),      32'(r.noch));
            chk({tag, ".overflow"}, 32'(overflow),   32'(r.ov));
            chk({tag, ".ch_count"}, 32'(ch_count),   32'(r.cnt));
        end
        step();
        chk({tag, ".pulse_end"}, 32'(choose_valid), 32'd0);
        chk({tag, ".busy_next"}, 32'(busy),         32'd1);
    endtask

    initial begin
        exp_t e;
        bit   saw;

        vecs[0] = '{0, 3, '{5, 2, 9, 0}, '{3, 1, 2, 0}, '{40, 90, 60, 0},
                    '{3, 16'd2, 16'd1, 16'd90, 1'b0, 1'b0, 4}};
        vecs[1] = '{0, 3, '{7, 3, 4, 0}, '{4, 2, 2, 0}, '{50, 50, 50, 0},
                    '{3, 16'd3, 16'd2, 16'd50, 1'b0, 1'b0, 4}};
        vecs[2] = '{0, 3, '{6, 8, 6, 0}, '{5, 1, 2, 0}, '{10, 20, 99, 0},
                    '{2, 16'd6, 16'd2, 16'd99, 1'b0, 1'b0, 3}};
        vecs[3] = '{2, 3, '{1, 2, 3, 0}, '{1, 1, 1, 0}, '{10, 20, 30, 0},
                    '{2, 16'd2, 16'd1, 16'd20, 1'b0, 1'b1, 3}};
        vecs[4] = '{0, 0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0},
                    '{0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 2}};
        vecs[5] = '{0, 2, '{1, 2, 0, 0}, '{1, 1, 0, 0}, '{16'h8000, 16'h7FFF, 0, 0},
                    '{2, 16'd1, 16'd1, 16'h8000, 1'b0, 1'b0, 3}};
        vecs[6] = '{100, 3, '{20, 22, 21, 0}, '{5, 4, 4, 0}, '{1, 1, 1, 0},
                    '{3, 16'd21, 16'd4, 16'd1, 1'b0, 1'b0, 4}};

        nrst = 1'b0; en_KCH = 1'b1; HB_reset = 1'b0; HB_CHlimit = '0;
        fch_valid = 1'b0; fCH_ID = '0; fCH_Hops = '0; fCH_QValue = '0;
        collect_done = 1'b0;
        #12;
        chk("reset.busy",     32'(busy),         32'd0);
        chk("reset.cv",       32'(choose_valid), 32'd0);
        chk("reset.no_ch",    32'(no_ch),        32'd0);
        chk("reset.overflow", 32'(overflow),     32'd0);
        chk("reset.ch_count", 32'(ch_count),     32'd0);
        chk("reset.chosenCH", 32'(chosenCH),     32'hFFFF);
        chk("reset.hops",     32'(hopsfromCH),   32'hFFFF);
        chk("reset.chosenQ",  32'(chosenQ),      32'hFFFF);
        nrst = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            start_window(vecs[i].limit);
            for (int k = 0; k < vecs[i].n; k++) send(vecs[i].id[k], vecs[i].hp[k], vecs[i].qv[k]);
            close_and_check($sformatf("vec%0d", i), vecs[i].e);
        end

        // Fill every slot with Q=index; one extra new ID must be dropped
        start_window(0);
        for (int k = 0; k < int'(N); k++) send(16'(100 + k), 16'd1, 16'(k));
        send(16'd999, 16'd1, 16'd1000);
        e = '{int'(N), 16'(100 + N - 1), 16'd1, 16'(N - 1), 1'b0, 1'b1, int'(N) + 1};
        close_and_check("full", e);
        chk("full.overflow_sticky", 32'(overflow), 32'd1);

        // Table retained across windows, then HB_reset (with en low) mid-SCAN
        start_window(0);
        send(16'd5, 16'd3, 16'd40);
        e = '{1, 16'd5, 16'd3, 16'd40, 1'b0, 1'b0, 2};
        close_and_check("append1", e);
        send(16'd2, 16'd1, 16'd90);
        e = '{2, 16'd2, 16'd1, 16'd90, 1'b0, 1'b0, 3};
        close_and_check("append2", e);
        send(16'd9, 16'd2, 16'd60);
        collect_done = 1'b1;
        step();
        collect_done = 1'b0;
        step();
        chk("hbscan.busy_before", 32'(busy), 32'd1);
        en_KCH   = 1'b0;
        HB_reset = 1'b1;
        step();
        HB_reset = 1'b0;
        en_KCH   = 1'b1;
        chk("hbscan.ch_count", 32'(ch_count),   32'd0);
        chk("hbscan.busy",     32'(busy),       32'd0);
        chk("hbscan.chosenCH", 32'(chosenCH),   32'hFFFF);
        chk("hbscan.hops",     32'(hopsfromCH), 32'hFFFF);
        chk("hbscan.chosenQ",  32'(chosenQ),    32'hFFFF);
        saw = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (choose_valid) saw = 1'b1;
            step();
        end
        chk("hbscan.no_cv", 32'(saw), 32'd0);

        // en_KCH low in COLLECT: tuple and collect_done are both dropped
        start_window(0);
        send(16'd4, 16'd1, 16'd30);
        en_KCH = 1'b0;
        send(16'd11, 16'd1, 16'd500);
        collect_done = 1'b1;
        step();
        collect_done = 1'b0;
        chk("enlow.busy",     32'(busy),     32'd1);
        chk("enlow.ch_count", 32'(ch_count), 32'd1);
        en_KCH = 1'b1;
        send(16'd6, 16'd1, 16'd20);
        e = '{2, 16'd4, 16'd1, 16'd30, 1'b0, 1'b0, 3};
        close_and_check("enlow", e);

        // Asynchronous reset in the middle of SCAN
        start_window(0);
        send(16'd3, 16'd1, 16'd5);
        e = '{1, 16'd3, 16'd1, 16'd5, 1'b0, 1'b0, 2};
        close_and_check("arst_pre", e);
        send(16'd8, 16'd1, 16'd9);
        collect_done = 1'b1;
        step();
        collect_done = 1'b0;
        #2;
        nrst = 1'b0;
        #1;
        chk("arst.ch_count", 32'(ch_count), 32'd0);
        chk("arst.busy",     32'(busy),     32'd0);
        chk("arst.chosenCH", 32'(chosenCH), 32'hFFFF);
        chk("arst.chosenQ",  32'(chosenQ),  32'hFFFF);
        #1;
        nrst = 1'b1;
        step();
        chk("arst.cv", 32'(choose_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
